complex_div: RTL and testbench
==============================

Name: complex_div

Overview:
- Iterative fixed-point complex divider q = a / b = a·conj(b) / |b|², the inverse operation of the receive-path complex multiplier.
- Used by the channel equaliser to divide received subcarrier samples by the channel estimate, or to undo a prior rotation.
- Sits beside the multiplier in openofdm_rx.
- Accepts one operand pair at a time, uses strobe handshakes and reports saturation and divide-by-zero.

Parameters:
- IN_WIDTH, 16, signed width of each input I/Q component.
- OUT_WIDTH, 16, signed width of each quotient component.
- FRAC, 12, fractional bits of the quotient (1.0 = 2^FRAC).

Ports:
- clock  in  1  single clock domain.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  when low, all state and outputs freeze (no advance, no accept).
- a_i  in  IN_WIDTH  numerator real, signed.
- a_q  in  IN_WIDTH  numerator imaginary, signed.
- b_i  in  IN_WIDTH  denominator real, signed.
- b_q  in  IN_WIDTH  denominator imaginary, signed.
- input_strobe  in  1  operands valid this cycle.
- in_ready  out  1  high when IDLE; a strobe is accepted only on edges where input_strobe & in_ready & enable.
- q_i  out  OUT_WIDTH  quotient real, signed.
- q_q  out  OUT_WIDTH  quotient imaginary, signed.
- output_strobe  out  1  one-cycle pulse; q_*, sat and div_zero are valid with it and hold until the next pulse.
- sat  out  1  at least one component saturated.
- div_zero  out  1  b was 0+0j.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, in_ready=1, q_i=q_q=0, output_strobe=0, sat=0, div_zero=0, all internal registers 0. Reset mid-operation discards the in-flight result; no output_strobe follows.
- FSM states: IDLE -> MULT -> PREP -> DIV -> DONE -> IDLE.
  - IDLE: on accept, register a and b, go to MULT.
  - MULT: register the four products ai·br, aq·bi, aq·br, ai·bi (2·IN_WIDTH bits each).
  - PREP:
    - num_i = ai·br + aq·bi; num_q = aq·br − ai·bi (2·IN_WIDTH+1 bits, signed).
    - den = br² + bi² (2·IN_WIDTH+1 bits, unsigned).
    - Record num signs; take magnitudes.
    - Per component, set ovf if |num|·2^FRAC ≥ den·2^(OUT_WIDTH−1).
  - DIV: OUT_WIDTH−1 cycles of restoring division, MSB first. Both components run in parallel on dividend |num|·2^FRAC, one quotient bit per component per cycle.
  - DONE: drive outputs, pulse output_strobe, return to IDLE.
- Rounding: truncate magnitude toward zero, then negate if num was negative.
- Saturation: symmetric, ±(2^(OUT_WIDTH−1)−1). sat=1 if either component saturated.
- Divide by zero: den==0 forces q_i=q_q=0, div_zero=1, sat=0. DIV still runs its fixed cycle count, so latency is constant.
- Latency:
  - output_strobe is high in the cycle following the (OUT_WIDTH+3)th rising edge after the accepting edge; with defaults that is 19 edges.
  - in_ready is low from the accepting edge until DONE is exited.
  - Maximum throughput is one operation per OUT_WIDTH+4 cycles.
- Strobes while in_ready=0 are ignored, not queued.
- Enable low stalls every state, including DONE; output_strobe does not pulse until enable returns. Latency stretches by the number of stalled cycles.
- Same-edge accept while DONE exits: not possible, since accept occurs only in IDLE; the earliest re-accept is the edge after DONE.

Test Plan:
- Real divide: a=(4096,0), b=(2048,0) -> q=(8192,0), sat=0, div_zero=0. Check output_strobe exactly 19 edges after accept and a single cycle wide.
- Complex divide: a=(1000,1000), b=(0,1000) -> q=(4096,−4096). Also a=(−300,700), b=(300,400) -> num=(190000,330000), den=250000 -> q=(3112,5406) truncated.
- Saturation: a=(32767,−32768), b=(1,0) -> q=(32767,−32767), sat=1.
- Divide by zero: b=(0,0), any a -> q=(0,0), div_zero=1, latency unchanged.
- Handshake and stall:
  - A second strobe 5 cycles after accept is ignored (single output_strobe, result of the first operands).
  - Deassert enable for 7 cycles mid-DIV -> output_strobe 26 edges after accept, same q.
- Reset mid-operation: pulse rstn low during DIV -> outputs 0, in_ready=1 immediately, no output_strobe afterwards. The next operation computes correctly.

Source files
------------

// File: rtl/complex_div.sv
// rtl/complex_div.sv - iterative fixed-point complex divider q = a*conj(b)/|b|^2
// Five-state FSM around a shared restoring divider that computes both quotient components in parallel.
module complex_div #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC      = 12
) (
    input  logic                 clock,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [IN_WIDTH-1:0]  a_i,
    input  logic [IN_WIDTH-1:0]  a_q,
    input  logic [IN_WIDTH-1:0]  b_i,
    input  logic [IN_WIDTH-1:0]  b_q,
    input  logic                 input_strobe,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] q_i,
    output logic [OUT_WIDTH-1:0] q_q,
    output logic                 output_strobe,
    output logic                 sat,
    output logic                 div_zero
);
    localparam int PW = 2 * IN_WIDTH;
    localparam int NW = PW + 1;
    localparam int RW = NW + FRAC + OUT_WIDTH;
    localparam int QW = OUT_WIDTH - 1;
    localparam int CW = $clog2(OUT_WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_PREP, S_DIV, S_DONE} state_t;

    state_t state_q, state_d;

    logic signed [IN_WIDTH-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
    logic signed [PW-1:0]       p_rr_q, p_ii_q, p_ir_q, p_ri_q;
    logic [NW-1:0]              mag_i_q, mag_q_q, den_q;
    logic                       neg_i_q, neg_q_q, ovf_i_q, ovf_q_q;
    logic [RW-1:0]              rem_i_q, rem_q_q, dsh_q;
    logic [QW-1:0]              quo_i_q, quo_q_q;
    logic [CW-1:0]              cnt_q;
    logic [OUT_WIDTH-1:0]       q_i_q, q_q_q;
    logic                       strobe_q, sat_q, dz_q;

    logic accept, in_mult, in_prep, in_div, in_done;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (input_strobe) state_d = S_MULT;
            S_MULT:  state_d = S_PREP;
            S_PREP:  state_d = S_DIV;
            S_DIV:   if (cnt_q == CW'(OUT_WIDTH - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_IDLE);
        accept   = in_ready & input_strobe;
        in_mult  = (state_q == S_MULT);
        in_prep  = (state_q == S_PREP);
        in_div   = (state_q == S_DIV);
        in_done  = (state_q == S_DONE);
    end

    logic signed [PW-1:0] sq_r, sq_i;
    logic signed [NW-1:0] num_i_c, num_q_c;
    logic [NW-1:0]        mag_i_c, mag_q_c, den_c;
    logic [RW-1:0]        lim_c;
    logic                 ovf_i_c, ovf_q_c;

    // Overflow test runs on the full-width dividend so saturation never depends on the divider loop.
    always_comb begin
        sq_r    = b_re_q * b_re_q;
        sq_i    = b_im_q * b_im_q;
        num_i_c = {p_rr_q[PW-1], p_rr_q} + {p_ii_q[PW-1], p_ii_q};
        num_q_c = {p_ir_q[PW-1], p_ir_q} - {p_ri_q[PW-1], p_ri_q};
        den_c   = {1'b0, sq_r} + {1'b0, sq_i};
        mag_i_c = num_i_c[NW-1] ? NW'(-num_i_c) : NW'(num_i_c);
        mag_q_c = num_q_c[NW-1] ? NW'(-num_q_c) : NW'(num_q_c);
        lim_c   = RW'(den_c) << (OUT_WIDTH - 1);
        ovf_i_c = (RW'(mag_i_c) << FRAC) >= lim_c;
        ovf_q_c = (RW'(mag_q_c) << FRAC) >= lim_c;
    end

    logic                 bit_i, bit_q;
    logic [OUT_WIDTH-1:0] qmag_i, qmag_q, fin_i, fin_q;

    always_comb begin
        bit_i  = rem_i_q >= dsh_q;
        bit_q  = rem_q_q >= dsh_q;
        qmag_i = ovf_i_q ? {1'b0, {QW{1'b1}}} : {1'b0, quo_i_q};
        qmag_q = ovf_q_q ? {1'b0, {QW{1'b1}}} : {1'b0, quo_q_q};
        fin_i  = neg_i_q ? -qmag_i : qmag_i;
        fin_q  = neg_q_q ? -qmag_q : qmag_q;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            a_re_q   <= '0;
            a_im_q   <= '0;
            b_re_q   <= '0;
            b_im_q   <= '0;
            p_rr_q   <= '0;
            p_ii_q   <= '0;
            p_ir_q   <= '0;
            p_ri_q   <= '0;
            mag_i_q  <= '0;
            mag_q_q  <= '0;
            den_q    <= '0;
            neg_i_q  <= 1'b0;
            neg_q_q  <= 1'b0;
            ovf_i_q  <= 1'b0;
            ovf_q_q  <= 1'b0;
            rem_i_q  <= '0;
            rem_q_q  <= '0;
            dsh_q    <= '0;
            quo_i_q  <= '0;
            quo_q_q  <= '0;
            cnt_q    <= '0;
            q_i_q    <= '0;
            q_q_q    <= '0;
            strobe_q <= 1'b0;
            sat_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else if (enable) begin
            strobe_q <= 1'b0;
            if (accept) begin
                a_re_q <= a_i;
                a_im_q <= a_q;
                b_re_q <= b_i;
                b_im_q <= b_q;
            end
            if (in_mult) begin
                p_rr_q <= a_re_q * b_re_q;
                p_ii_q <= a_im_q * b_im_q;
                p_ir_q <= a_im_q * b_re_q;
                p_ri_q <= a_re_q * b_im_q;
            end
            if (in_prep) begin
                mag_i_q <= mag_i_c;
                mag_q_q <= mag_q_c;
                den_q   <= den_c;
                neg_i_q <= num_i_c[NW-1];
                neg_q_q <= num_q_c[NW-1];
                ovf_i_q <= ovf_i_c;
                ovf_q_q <= ovf_q_c;
                cnt_q   <= '0;
            end
            // First DIV cycle seeds the remainders and the pre-shifted divisor; the rest yield one bit each.
            if (in_div) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    rem_i_q <= RW'(mag_i_q) << FRAC;
                    rem_q_q <= RW'(mag_q_q) << FRAC;
                    dsh_q   <= RW'(den_q) << (OUT_WIDTH - 2);
                    quo_i_q <= '0;
                    quo_q_q <= '0;
                end else begin
                    if (bit_i) rem_i_q <= rem_i_q - dsh_q;
                    if (bit_q) rem_q_q <= rem_q_q - dsh_q;
                    quo_i_q <= {quo_i_q[QW-2:0], bit_i};
                    quo_q_q <= {quo_q_q[QW-2:0], bit_q};
                    dsh_q   <= dsh_q >> 1;
                end
            end
            if (in_done) begin
                strobe_q <= 1'b1;
                if (den_q == '0) begin
                    q_i_q <= '0;
                    q_q_q <= '0;
                    sat_q <= 1'b0;
                    dz_q  <= 1'b1;
                end else begin
                    q_i_q <= fin_i;
                    q_q_q <= fin_q;
                    sat_q <= ovf_i_q | ovf_q_q;
                    dz_q  <= 1'b0;
                end
            end
        end
    end

    assign q_i           = q_i_q;
    assign q_q           = q_q_q;
    assign output_strobe = strobe_q;
    assign sat           = sat_q;
    assign div_zero      = dz_q;

endmodule

// File: tb/tb_complex_div.sv
// tb/tb_complex_div.sv - directed-vector bench for complex_div
// Hand-computed quotients, latency, handshake, stall and reset-abort cases.
module tb_complex_div;
    logic        clk;
    logic        rstn;
    logic        enable;
    logic [15:0] a_i, a_q, b_i, b_q;
    logic        input_strobe;
    logic        in_ready;
    logic [15:0] q_i, q_q;
    logic        output_strobe;
    logic        sat;
    logic        div_zero;

    int n_checks;
    int n_errors;

    complex_div #(.IN_WIDTH(16), .OUT_WIDTH(16), .FRAC(12)) dut (
        .clock         (clk),
        .rstn          (rstn),
        .enable        (enable),
        .a_i           (a_i),
        .a_q           (a_q),
        .b_i           (b_i),
        .b_q           (b_q),
        .input_strobe  (input_strobe),
        .in_ready      (in_ready),
        .q_i           (q_i),
        .q_q           (q_q),
        .output_strobe (output_strobe),
        .sat           (sat),
        .div_zero      (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: plain, 1: second strobe mid-flight, 2: enable low for 7 cycles mid-DIV
    task automatic run_op(input string tag, input int ai, input int aq, input int bi, input int bq,
                          input int eqi, input int eqq, input int esat, input int edz,
                          input int elat, input int mode);
        int edges;
        int strobes;
        bit seen;
        a_i = 16'(ai); a_q = 16'(aq); b_i = 16'(bi); b_q = 16'(bq);
        input_strobe = 1'b1;
        @(posedge clk);
        #1;
        input_strobe = 1'b0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            if (output_strobe) seen = 1'b1;
            if (mode == 1 && edges == 5) begin
                a_i = 16'd100; a_q = 16'd100; b_i = 16'd1; b_q = 16'd1;
                input_strobe = 1'b1;
            end
            if (mode == 1 && edges == 6) input_strobe = 1'b0;
            if (mode == 2 && edges == 5) enable = 1'b0;
            if (mode == 2 && edges == 12) enable = 1'b1;
        end
        check({tag, " latency"}, edges, elat);
        check({tag, " q_i"}, int'($signed(q_i)), eqi);
        check({tag, " q_q"}, int'($signed(q_q)), eqq);
        check({tag, " sat"}, int'(sat), esat);
        check({tag, " div_zero"}, int'(div_zero), edz);
        @(posedge clk);
        #1;
        check({tag, " strobe width"}, int'(output_strobe), 0);
        check({tag, " q_i hold"}, int'($signed(q_i)), eqi);
        check({tag, " in_ready after"}, int'(in_ready), 1);
        if (mode == 1) begin
            strobes = 0;
            for (int i = 0; i < 25; i++) begin
                @(posedge clk);
                #1;
                if (output_strobe) strobes++;
            end
            check({tag, " extra strobes"}, strobes, 0);
        end
    endtask

    initial begin
        int strobes;
        n_checks = 0;
        n_errors = 0;
        rstn = 1'b0;
        enable = 1'b1;
        input_strobe = 1'b0;
        a_i = '0; a_q = '0; b_i = '0; b_q = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", int'(in_ready), 1);
        check("rst q_i", int'(q_i), 0);
        check("rst q_q", int'(q_q), 0);
        check("rst strobe", int'(output_strobe), 0);
        check("rst sat", int'(sat), 0);
        check("rst div_zero", int'(div_zero), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        run_op("real",     4096,      0, 2048,    0,   8192,      0, 0, 0, 19, 0);
        run_op("cplx1",    1000,   1000,    0, 1000,   4096,  -4096, 0, 0, 19, 0);
        run_op("cplx2",    -300,    700,  300,  400,   3112,   5406, 0, 0, 19, 0);
        run_op("negtrunc", -100,      0,  300,    0,  -1365,      0, 0, 0, 19, 0);
        run_op("sat",     32767, -32768,    1,    0,  32767, -32767, 1, 0, 19, 0);
        run_op("bound8",      8,     -7,    1,    0,  32767, -28672, 1, 0, 19, 0);
        run_op("bound7",      7,      0,    1,    0,  28672,      0, 0, 0, 19, 0);
        run_op("divzero",  1234,  -5678,    0,    0,      0,      0, 0, 1, 19, 0);
        run_op("ignore2",  4096,      0, 2048,    0,   8192,      0, 0, 0, 19, 1);
        run_op("stall",    -300,    700,  300,  400,   3112,   5406, 0, 0, 26, 2);

        a_i = 16'd4096; a_q = 16'd0; b_i = 16'd2048; b_q = 16'd0;
        input_strobe = 1'b1;
        @(posedge clk);
        #1;
        input_strobe = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("abort q_i", int'(q_i), 0);
        check("abort in_ready", int'(in_ready), 1);
        check("abort strobe", int'(output_strobe), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (output_strobe) strobes++;
        end
        check("abort no strobe", strobes, 0);

        run_op("post_rst", 1000, 1000, 0, 1000, 4096, -4096, 0, 0, 19, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
